// File: rtl/pattern_serial_loader_if.sv
// Host-side and serial-chain signals of the pattern buffer serial loader.
// The slave modport is the loader's view; master is the host/chain side.
interface pattern_serial_loader_if #(
  parameter int buffer_size  = 22,
  parameter int buffer_width = 8
);
  localparam int N = buffer_size * buffer_width;

  logic         start;
  logic         ready;
  logic [2:0]   addr_in;
  logic [N-1:0] data_in;
  logic         sclk;
  logic         sin;
  logic         ssel;
  logic [2:0]   saddr;
  logic         sout;
  logic         done;
  logic [N-1:0] rdata;

  modport slave (
    input  start, addr_in, data_in, sout,
    output ready, sclk, sin, ssel, saddr, done, rdata
  );

  modport master (
    output start, addr_in, data_in, sout,
    input  ready, sclk, sin, ssel, saddr, done, rdata
  );
endinterface

// File: rtl/pattern_serial_loader.sv
// Serial configuration master: shifts one buffer image out MSB first on sclk/sin.
// Define PATTERN_LOADER_READBACK_EN to capture the chain's sout return into rdata.
module pattern_serial_loader #(
  parameter int buffer_size  = 22,
  parameter int buffer_width = 8,
  parameter int clk_div      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pattern_serial_loader_if.slave   bus
);
  localparam int N  = buffer_size * buffer_width;
  localparam int CW = $clog2(N + 1);
  localparam logic [7:0]    DIV_LAST = 8'(clk_div - 1);
  localparam logic [CW-1:0] BITS_N   = CW'(N);
  localparam logic [CW-1:0] BITS_ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, DONE} state_t;

  state_t        state;
  logic [7:0]    div_cnt;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  shift_reg;
  logic          div_last;

  assign div_last = (div_cnt == DIV_LAST);

`ifdef PATTERN_LOADER_READBACK_EN
  logic [N-1:0] rb_reg;
`else
  assign bus.rdata = '0;
`endif

  // Every phase lasts clk_div cycles; sin only moves on the edge that drops sclk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      bus.ready <= 1'b1;
      bus.sclk  <= 1'b0;
      bus.sin   <= 1'b0;
      bus.ssel  <= 1'b0;
      bus.saddr <= '0;
      bus.done  <= 1'b0;
`ifdef PATTERN_LOADER_READBACK_EN
      rb_reg    <= '0;
      bus.rdata <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_reg <= bus.data_in;
            bus.saddr <= bus.addr_in;
            bit_cnt   <= BITS_N;
            div_cnt   <= '0;
            bus.ready <= 1'b0;
            bus.ssel  <= 1'b1;
            bus.sin   <= bus.data_in[N-1];
            state     <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (div_last) begin
            div_cnt  <= '0;
            bus.sclk <= 1'b1;
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (div_last) begin
            div_cnt  <= '0;
            bus.sclk <= 1'b0;
            bit_cnt  <= bit_cnt - BITS_ONE;
`ifdef PATTERN_LOADER_READBACK_EN
            rb_reg   <= {rb_reg[N-2:0], bus.sout};
`endif
            if (bit_cnt == BITS_ONE) begin
              state <= HOLD;
            end else begin
              shift_reg <= {shift_reg[N-2:0], 1'b0};
              bus.sin   <= shift_reg[N-2];
              state     <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (div_last) begin
            div_cnt   <= '0;
            bus.ssel  <= 1'b0;
            bus.sin   <= 1'b0;
            bus.done  <= 1'b1;
`ifdef PATTERN_LOADER_READBACK_EN
            bus.rdata <= rb_reg;
`endif
            state     <= DONE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_serial_loader.sv
// Bench for pattern_serial_loader: directed and random frames against a bit-stream/timing model,
// with a looped-back return register standing in for the buffer chain.
module tb_pattern_serial_loader;
  localparam int BS = 2;
  localparam int BW = 8;
  localparam int CD = 2;
  localparam int N  = BS * BW;
  localparam int FRAME_CYCLES = (2 * N + 1) * CD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_serial_loader_if #(.buffer_size(BS), .buffer_width(BW)) ifc ();

  pattern_serial_loader #(.buffer_size(BS), .buffer_width(BW), .clk_div(CD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the buffer chain: presents its MSB and shifts on every sclk fall.
  logic [N-1:0] loop_reg = '0;
  assign ifc.sout = loop_reg[N-1];
  always @(negedge ifc.sclk) loop_reg = loop_reg << 1;

  int           ssel_cycles, done_count, rise_count, first_rise_cyc, saddr_errs, sin_rise_errs;
  logic [N-1:0] sin_word;
  logic [2:0]   exp_addr;
  logic         prev_sclk = 1'b0;
  logic         prev_sin  = 1'b0;

  // Frame observer, sampling mid-cycle.
  always @(negedge clk) begin
    if (ifc.ssel) begin
      ssel_cycles++;
      if (ifc.saddr !== exp_addr) saddr_errs++;
    end
    if (ifc.done) done_count++;
    if (ifc.sclk && !prev_sclk) begin
      if (rise_count == 0) first_rise_cyc = cyc;
      rise_count++;
      sin_word = {sin_word[N-2:0], ifc.sin};
      if (ifc.sin !== prev_sin) sin_rise_errs++;
    end
    prev_sclk = ifc.sclk;
    prev_sin  = ifc.sin;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] expected_rdata(input logic [N-1:0] preload);
`ifdef PATTERN_LOADER_READBACK_EN
    return preload;
`else
    return '0;
`endif
  endfunction

  // Starts one frame and waits (bounded) for done; optional stray start mid-frame.
  task automatic apply_stimulus(input logic [N-1:0] data, input logic [2:0] addr,
                                input logic [N-1:0] preload, input bit poke,
                                output int acc_cyc, output int done_cyc);
    @(negedge clk);
    ssel_cycles = 0; done_count = 0; rise_count = 0; first_rise_cyc = -1;
    saddr_errs = 0; sin_rise_errs = 0; sin_word = '0;
    exp_addr = addr;
    loop_reg = preload;
    check_output("ready_before_start", 32'(ifc.ready), 32'd1);
    ifc.start = 1'b1;
    ifc.data_in = data;
    ifc.addr_in = addr;
    acc_cyc = cyc;
    done_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) begin
        ifc.start = 1'b0;
        ifc.data_in = N'($urandom);
        ifc.addr_in = 3'($urandom);
      end
      if (poke && i == 20) begin
        ifc.start = 1'b1;
        ifc.data_in = ~data;
        ifc.addr_in = ~addr;
      end else if (poke && i == 21) begin
        ifc.start = 1'b0;
      end
      if (ifc.done) begin
        done_cyc = cyc;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic verify_frame(input string tag, input logic [N-1:0] data,
                              input logic [N-1:0] exp_rd, input int acc_cyc, input int done_cyc);
    check_output({tag, "_done_latency"}, 32'(done_cyc - acc_cyc), 32'(1 + FRAME_CYCLES));
    check_output({tag, "_ssel_cycles"}, 32'(ssel_cycles), 32'(FRAME_CYCLES));
    check_output({tag, "_first_sclk"}, 32'(first_rise_cyc - acc_cyc), 32'(1 + CD));
    check_output({tag, "_rises"}, 32'(rise_count), 32'(N));
    check_output({tag, "_sin_stream"}, 32'(sin_word), 32'(data));
    check_output({tag, "_saddr_errs"}, 32'(saddr_errs), 32'd0);
    check_output({tag, "_sin_at_rise"}, 32'(sin_rise_errs), 32'd0);
    check_output({tag, "_done_pulses"}, 32'(done_count), 32'd1);
    check_output({tag, "_rdata"}, 32'(ifc.rdata), 32'(exp_rd));
    check_output({tag, "_ready_after"}, 32'(ifc.ready), 32'd1);
  endtask

  initial begin
    int acc, dn, rises;
    logic [N-1:0] d, p;
    logic [2:0]   a;
    logic         my_prev;

    ifc.start = 1'b0;
    ifc.data_in = '0;
    ifc.addr_in = '0;

    repeat (3) @(negedge clk);
    check_output("rst_ready", 32'(ifc.ready), 32'd1);
    check_output("rst_ssel", 32'(ifc.ssel), 32'd0);
    check_output("rst_sclk", 32'(ifc.sclk), 32'd0);
    check_output("rst_sin", 32'(ifc.sin), 32'd0);
    check_output("rst_saddr", 32'(ifc.saddr), 32'd0);
    check_output("rst_done", 32'(ifc.done), 32'd0);
    check_output("rst_rdata", 32'(ifc.rdata), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_output("idle_ready", 32'(ifc.ready), 32'd1);
    check_output("idle_ssel", 32'(ifc.ssel), 32'd0);
    check_output("idle_sclk", 32'(ifc.sclk), 32'd0);
    check_output("idle_rdata", 32'(ifc.rdata), 32'd0);

    $display("[TB] directed frame A53C addr 5");
    apply_stimulus(16'hA53C, 3'd5, 16'h1234, 1'b0, acc, dn);
    verify_frame("frame_a53c", 16'hA53C, expected_rdata(16'h1234), acc, dn);
    check_output("idle_saddr_hold", 32'(ifc.saddr), 32'd5);
    check_output("idle_sin_zero", 32'(ifc.sin), 32'd0);

    $display("[TB] busy start ignored");
    d = N'($urandom); a = 3'($urandom); p = N'($urandom);
    apply_stimulus(d, a, p, 1'b1, acc, dn);
    verify_frame("busy_start", d, expected_rdata(p), acc, dn);

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      d = N'($urandom); a = 3'($urandom); p = N'($urandom);
      if (k == 0) begin d = '1; p = '0; end
      if (k == 1) begin d = '0; p = '1; end
      apply_stimulus(d, a, p, 1'b0, acc, dn);
      verify_frame($sformatf("rand%0d", k), d, expected_rdata(p), acc, dn);
    end

    $display("[TB] reset after 7th sclk rise");
    @(negedge clk);
    exp_addr = 3'd3;
    ifc.start = 1'b1;
    ifc.data_in = 16'hC0DE;
    ifc.addr_in = 3'd3;
    rises = 0;
    my_prev = 1'b0;
    for (int i = 0; i < 400 && rises < 7; i++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      if (ifc.sclk && !my_prev) rises++;
      my_prev = ifc.sclk;
    end
    check_output("abort_rises_reached", 32'(rises), 32'd7);
    rst_n = 1'b0;
    #1;
    check_output("abort_ssel", 32'(ifc.ssel), 32'd0);
    check_output("abort_sclk", 32'(ifc.sclk), 32'd0);
    check_output("abort_ready", 32'(ifc.ready), 32'd1);
    check_output("abort_saddr", 32'(ifc.saddr), 32'd0);
    check_output("abort_done", 32'(ifc.done), 32'd0);
    done_count = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME_CYCLES + 5) @(negedge clk);
    check_output("abort_no_done", 32'(done_count), 32'd0);
    check_output("abort_rdata", 32'(ifc.rdata), 32'd0);

    d = N'($urandom); a = 3'($urandom); p = N'($urandom);
    apply_stimulus(d, a, p, 1'b0, acc, dn);
    verify_frame("after_reset", d, expected_rdata(p), acc, dn);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
